mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues word/byte loads and stores over a req/ack data port,
// stalls upstream while an access is outstanding, and registers results into MEM/WB.
module mem_stage #(
    parameter int AW = 32
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          memRead,
    input  logic          memWrite,
    input  logic          word,
    input  logic          memToReg,
    input  logic          regWrite,
    input  logic [31:0]   result,
    input  logic [31:0]   readData2,
    input  logic [4:0]    rd,
    input  logic          exception,
    input  logic [31:0]   faulty_address,
    input  logic [31:0]   pc,
    input  logic          flush,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          wb_regWrite,
    output logic          wb_memToReg,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_result,
    output logic [31:0]   wb_loadData,
    output logic [31:0]   wb_pc,
    output logic [31:0]   wb_faulty_address,
    output logic          wb_exception
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]  state;
    logic        flush_pending;
    logic        acc_word;
    logic [1:0]  acc_lane;
    logic        misaligned;
    logic        is_access;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_fmt;

    logic        n_regWrite;
    logic        n_memToReg;
    logic [4:0]  n_rd;
    logic [31:0] n_result;
    logic [31:0] n_loadData;
    logic [31:0] n_pc;
    logic [31:0] n_faulty_address;
    logic        n_exception;

    // An upstream exception outranks alignment, so misalignment is only reported for clean accesses
    assign misaligned = (memRead | memWrite) & word & (result[1:0] != 2'b00) & ~exception;
    assign is_access  = (memRead | memWrite) & ~exception & ~misaligned;
    assign be_next    = word ? 4'hF : (4'b0001 << result[1:0]);
    assign wdata_next = word ? readData2 : {4{readData2[7:0]}};

    always_comb begin
        if (state == IDLE)
            stall_mem = is_access & ~flush;
        else
            stall_mem = ~mem_ack;
    end

    always_comb begin
        load_fmt = mem_rdata;
        if (!acc_word) begin
            case (acc_lane)
                2'd0:    load_fmt = {24'h0, mem_rdata[7:0]};
                2'd1:    load_fmt = {24'h0, mem_rdata[15:8]};
                2'd2:    load_fmt = {24'h0, mem_rdata[23:16]};
                default: load_fmt = {24'h0, mem_rdata[31:24]};
            endcase
        end
    end

    // Request is held stable until ack; reset abandons it outright
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= 4'h0;
            mem_wdata     <= 32'h0;
            flush_pending <= 1'b0;
            acc_word      <= 1'b0;
            acc_lane      <= 2'b00;
        end else if (state == IDLE) begin
            flush_pending <= 1'b0;
            if (is_access && !flush) begin
                state     <= ACCESS;
                mem_req   <= 1'b1;
                mem_we    <= memWrite;
                mem_addr  <= {result[AW-1:2], 2'b00};
                mem_be    <= be_next;
                mem_wdata <= wdata_next;
                acc_word  <= word;
                acc_lane  <= result[1:0];
            end
        end else if (mem_ack) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            flush_pending <= 1'b0;
        end else if (flush) begin
            flush_pending <= 1'b1;
        end
    end

    // Anything not explicitly captured below enters MEM/WB as an all-zero bubble
    always_comb begin
        n_regWrite       = 1'b0;
        n_memToReg       = 1'b0;
        n_rd             = 5'd0;
        n_result         = 32'h0;
        n_loadData       = 32'h0;
        n_pc             = 32'h0;
        n_faulty_address = 32'h0;
        n_exception      = 1'b0;
        if (!stall_mem) begin
            if (state == ACCESS) begin
                if (!(flush || flush_pending)) begin
                    n_regWrite = regWrite;
                    n_memToReg = memToReg;
                    n_rd       = rd;
                    n_result   = result;
                    n_loadData = load_fmt;
                    n_pc       = pc;
                end
            end else if (!flush) begin
                n_regWrite       = regWrite & ~exception & ~misaligned;
                n_memToReg       = memToReg & ~misaligned;
                n_rd             = rd;
                n_result         = result;
                n_pc             = pc;
                n_exception      = exception | misaligned;
                n_faulty_address = exception ? faulty_address :
                                   (misaligned ? result : 32'h0);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wb_regWrite       <= 1'b0;
            wb_memToReg       <= 1'b0;
            wb_rd             <= 5'd0;
            wb_result         <= 32'h0;
            wb_loadData       <= 32'h0;
            wb_pc             <= 32'h0;
            wb_faulty_address <= 32'h0;
            wb_exception      <= 1'b0;
        end else begin
            wb_regWrite       <= n_regWrite;
            wb_memToReg       <= n_memToReg;
            wb_rd             <= n_rd;
            wb_result         <= n_result;
            wb_loadData       <= n_loadData;
            wb_pc             <= n_pc;
            wb_faulty_address <= n_faulty_address;
            wb_exception      <= n_exception;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: the bench plays upstream pipeline and data memory,
// predicts every cycle from a transaction-level model, and checks on each falling edge.
module tb_mem_stage;

    typedef struct packed {
        logic        memRead, memWrite, word, memToReg, regWrite;
        logic [31:0] result;
        logic [31:0] readData2;
        logic [4:0]  rd;
        logic        exception;
        logic [31:0] faulty;
        logic [31:0] pc;
        logic        flush;
    } instr_t;

    typedef struct packed {
        logic        regWrite, memToReg;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] loadData;
        logic [31:0] pc;
        logic [31:0] faulty;
        logic        exception;
    } wb_t;

    logic        clock, rst_n;
    logic        memRead, memWrite, word, memToReg, regWrite;
    logic [31:0] result, readData2, faulty_address, pc;
    logic [4:0]  rd;
    logic        exception, flush;
    logic        stall_mem, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_regWrite, wb_memToReg, wb_exception;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result, wb_loadData, wb_pc, wb_faulty_address;

    int  tests = 0;
    int  failures = 0;
    bit  chk_en = 0;

    logic        exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    wb_t         exp_wb, next_wb;

    bit          lit_req_on = 0, lit_wb_on = 0, lit_rdata_on = 0;
    logic        lit_we, lit_wb_rw, lit_wb_exc;
    logic [3:0]  lit_be;
    logic [31:0] lit_addr, lit_wdata, lit_rdata, lit_wb_ld, lit_wb_fa;

    mem_stage #(.AW(32)) dut (
        .clock(clock), .rst_n(rst_n),
        .memRead(memRead), .memWrite(memWrite), .word(word),
        .memToReg(memToReg), .regWrite(regWrite),
        .result(result), .readData2(readData2), .rd(rd),
        .exception(exception), .faulty_address(faulty_address), .pc(pc),
        .flush(flush), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_loadData(wb_loadData), .wb_pc(wb_pc),
        .wb_faulty_address(wb_faulty_address), .wb_exception(wb_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural rules for a single-cycle (non-memory, excepted or misaligned) instruction
    function automatic wb_t passThrough(input instr_t in);
        wb_t w;
        bit  mis;
        mis = (in.memRead || in.memWrite) && in.word && (in.result % 4 != 0) && !in.exception;
        w.regWrite  = in.regWrite && !in.exception && !mis;
        w.memToReg  = mis ? 1'b0 : in.memToReg;
        w.rd        = in.rd;
        w.result    = in.result;
        w.loadData  = 32'h0;
        w.pc        = in.pc;
        w.exception = in.exception || mis;
        w.faulty    = in.exception ? in.faulty : (mis ? in.result : 32'h0);
        return w;
    endfunction

    function automatic wb_t accessDone(input instr_t in, input logic [31:0] rdata);
        wb_t w;
        int  sh;
        sh = 8 * int'(in.result % 4);
        w.regWrite  = in.regWrite;
        w.memToReg  = in.memToReg;
        w.rd        = in.rd;
        w.result    = in.result;
        w.loadData  = in.word ? rdata : ((rdata >> sh) & 32'hFF);
        w.pc        = in.pc;
        w.exception = 1'b0;
        w.faulty    = 32'h0;
        return w;
    endfunction

    task automatic applyStimulus(input instr_t in);
        memRead        = in.memRead;
        memWrite       = in.memWrite;
        word           = in.word;
        memToReg       = in.memToReg;
        regWrite       = in.regWrite;
        result         = in.result;
        readData2      = in.readData2;
        rd             = in.rd;
        exception      = in.exception;
        faulty_address = in.faulty;
        pc             = in.pc;
        flush          = in.flush;
    endtask

    // Start of every cycle: last edge's prediction becomes the expected MEM/WB content
    task automatic beginCycle();
        exp_wb = next_wb;
        if (lit_wb_on) begin
            checkOutput("lit_wb_loadData", wb_loadData, lit_wb_ld);
            checkOutput("lit_wb_regWrite", 32'(wb_regWrite), 32'(lit_wb_rw));
            checkOutput("lit_wb_exception", 32'(wb_exception), 32'(lit_wb_exc));
            checkOutput("lit_wb_faulty_address", wb_faulty_address, lit_wb_fa);
            lit_wb_on = 0;
        end
    endtask

    task automatic setExpectedRequest(input instr_t in);
        exp_we    = in.memWrite;
        exp_addr  = in.result & ~32'h3;
        exp_be    = in.word ? 4'hF : 4'(1 << (in.result % 4));
        exp_wdata = in.word ? in.readData2 : (in.readData2 & 32'hFF) * 32'h01010101;
    endtask

    task automatic runInstr(input instr_t in, input int lat, input int flushAt);
        bit acc, flushed;
        acc = (in.memRead || in.memWrite) && !in.exception && !(in.word && (in.result % 4 != 0));
        @(posedge clock); #1;
        beginCycle();
        exp_req = 1'b0;
        applyStimulus(in);
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        if (!acc || in.flush) begin
            exp_stall = 1'b0;
            next_wb   = in.flush ? '0 : passThrough(in);
            return;
        end
        exp_stall = 1'b1;
        next_wb   = '0;
        setExpectedRequest(in);
        flushed = 0;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clock); #1;
            beginCycle();
            exp_req = 1'b1;
            if (c == 1 && lit_req_on) begin
                checkOutput("lit_mem_be", 32'(mem_be), 32'(lit_be));
                checkOutput("lit_mem_addr", mem_addr, lit_addr);
                checkOutput("lit_mem_wdata", mem_wdata, lit_wdata);
                checkOutput("lit_mem_we", 32'(mem_we), 32'(lit_we));
                lit_req_on = 0;
            end
            flush = (c == flushAt);
            if (flush) flushed = 1;
            mem_ack   = (c == lat);
            mem_rdata = (c == lat && lit_rdata_on) ? lit_rdata : $urandom;
            exp_stall = (c != lat);
            next_wb   = (c == lat && !flushed) ? accessDone(in, mem_rdata) : '0;
        end
        lit_rdata_on = 0;
    endtask

    function automatic instr_t randInstr();
        instr_t i;
        i.memRead   = 1'($urandom_range(0, 1));
        i.memWrite  = 1'($urandom_range(0, 1));
        i.word      = 1'($urandom_range(0, 1));
        i.memToReg  = 1'($urandom_range(0, 1));
        i.regWrite  = 1'($urandom_range(0, 1));
        i.result    = $urandom;
        if ($urandom_range(0, 1) == 1) i.result[1:0] = 2'b00;
        i.readData2 = $urandom;
        i.rd        = 5'($urandom_range(0, 31));
        i.exception = ($urandom_range(0, 7) == 0);
        i.faulty    = $urandom;
        i.pc        = $urandom;
        i.flush     = ($urandom_range(0, 7) == 0);
        return i;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            checkOutput("stall_mem", 32'(stall_mem), 32'(exp_stall));
            checkOutput("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
                checkOutput("mem_addr", mem_addr, exp_addr);
                checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
                checkOutput("mem_wdata", mem_wdata, exp_wdata);
            end
            checkOutput("wb_regWrite", 32'(wb_regWrite), 32'(exp_wb.regWrite));
            checkOutput("wb_memToReg", 32'(wb_memToReg), 32'(exp_wb.memToReg));
            checkOutput("wb_rd", 32'(wb_rd), 32'(exp_wb.rd));
            checkOutput("wb_result", wb_result, exp_wb.result);
            checkOutput("wb_loadData", wb_loadData, exp_wb.loadData);
            checkOutput("wb_pc", wb_pc, exp_wb.pc);
            checkOutput("wb_faulty_address", wb_faulty_address, exp_wb.faulty);
            checkOutput("wb_exception", 32'(wb_exception), 32'(exp_wb.exception));
        end
    end

    initial begin
        instr_t in, nop;
        int lat, flushAt;
        nop = '0;
        rst_n = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(nop);
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
        exp_wb = '0; next_wb = '0;
        @(posedge clock); #1;
        chk_en = 1;
        @(posedge clock); #1;
        rst_n = 1'b1;

        // Word load at 0x100, ack on the third request cycle
        in = '0; in.memRead = 1; in.word = 1; in.memToReg = 1; in.regWrite = 1;
        in.result = 32'h100; in.rd = 5'd5; in.pc = 32'h40;
        lit_req_on = 1; lit_be = 4'hF; lit_addr = 32'h100; lit_wdata = 32'h0; lit_we = 1'b0;
        lit_rdata_on = 1; lit_rdata = 32'hDEADBEEF;
        runInstr(in, 3, 0);
        lit_wb_on = 1; lit_wb_ld = 32'hDEADBEEF; lit_wb_rw = 1'b1; lit_wb_exc = 1'b0; lit_wb_fa = 32'h0;

        // Byte store to lane 3
        in = '0; in.memWrite = 1; in.result = 32'h203; in.readData2 = 32'h12345678; in.pc = 32'h44;
        lit_req_on = 1; lit_be = 4'b1000; lit_addr = 32'h200; lit_wdata = 32'h78787878; lit_we = 1'b1;
        lit_rdata_on = 1; lit_rdata = 32'h0;
        runInstr(in, 1, 0);
        lit_wb_on = 1; lit_wb_ld = 32'h0; lit_wb_rw = 1'b0; lit_wb_exc = 1'b0; lit_wb_fa = 32'h0;

        // Byte load from lane 2
        in = '0; in.memRead = 1; in.memToReg = 1; in.regWrite = 1; in.result = 32'h202; in.rd = 5'd9;
        lit_rdata_on = 1; lit_rdata = 32'hAABBCCDD;
        runInstr(in, 2, 0);
        lit_wb_on = 1; lit_wb_ld = 32'h000000BB; lit_wb_rw = 1'b1; lit_wb_exc = 1'b0; lit_wb_fa = 32'h0;

        // Misaligned word load
        in = '0; in.memRead = 1; in.word = 1; in.regWrite = 1; in.memToReg = 1; in.result = 32'h102;
        runInstr(in, 1, 0);
        lit_wb_on = 1; lit_wb_ld = 32'h0; lit_wb_rw = 1'b0; lit_wb_exc = 1'b1; lit_wb_fa = 32'h102;

        // Flush mid-access, then a plain ALU instruction
        in = '0; in.memRead = 1; in.word = 1; in.regWrite = 1; in.result = 32'h400; in.rd = 5'd3;
        runInstr(in, 3, 2);
        lit_wb_on = 1; lit_wb_ld = 32'h0; lit_wb_rw = 1'b0; lit_wb_exc = 1'b0; lit_wb_fa = 32'h0;
        in = '0; in.regWrite = 1; in.rd = 5'd7; in.result = 32'h55; in.pc = 32'h60;
        runInstr(in, 1, 0);

        // Reset while a request is outstanding, then a stray ack
        in = '0; in.memRead = 1; in.word = 1; in.regWrite = 1; in.result = 32'h300; in.rd = 5'd4;
        @(posedge clock); #1;
        beginCycle(); exp_req = 1'b0; applyStimulus(in); mem_ack = 1'b0;
        exp_stall = 1'b1; next_wb = '0; setExpectedRequest(in);
        @(posedge clock); #1;
        beginCycle(); exp_req = 1'b1; rst_n = 1'b0; exp_stall = 1'b1; next_wb = '0;
        @(posedge clock); #1;
        beginCycle(); exp_req = 1'b0; rst_n = 1'b1;
        nop.regWrite = 1; nop.rd = 5'd2; nop.result = 32'h77;
        applyStimulus(nop); mem_ack = 1'b1; exp_stall = 1'b0; next_wb = passThrough(nop);

        for (int n = 0; n < 300; n++) begin
            in = randInstr();
            lat = $urandom_range(1, 4);
            flushAt = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
            runInstr(in, lat, flushAt);
        end
        nop = '0;
        runInstr(nop, 1, 0);
        runInstr(nop, 1, 0);
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
